// File: rtl/regfile_arbiter_if.sv
// Bundles the read requester, both write-back requesters and the register-file
// port of regfile_arbiter; slave is the arbiter side, master the environment side.
interface regfile_arbiter_if;
    logic        rd_valid;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic        rd_ready;
    logic        rd_rvalid;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;

    logic        wr0_valid;
    logic [3:0]  wr0_dst;
    logic [63:0] wr0_data;
    logic        wr0_ready;

    logic        wr1_valid;
    logic [3:0]  wr1_dst;
    logic [63:0] wr1_data;
    logic        wr1_ready;

    logic [7:0]  rf_sel;
    logic        rf_load;
    logic [63:0] rf_d;
    logic [63:0] rf_a;
    logic [63:0] rf_b;

    modport slave (
        input  rd_valid, rd_a, rd_b,
        output rd_ready, rd_rvalid, rd_data_a, rd_data_b,
        input  wr0_valid, wr0_dst, wr0_data,
        output wr0_ready,
        input  wr1_valid, wr1_dst, wr1_data,
        output wr1_ready,
        output rf_sel, rf_load, rf_d,
        input  rf_a, rf_b
    );

    modport master (
        output rd_valid, rd_a, rd_b,
        input  rd_ready, rd_rvalid, rd_data_a, rd_data_b,
        output wr0_valid, wr0_dst, wr0_data,
        input  wr0_ready,
        output wr1_valid, wr1_dst, wr1_data,
        input  wr1_ready,
        input  rf_sel, rf_load, rf_d,
        output rf_a, rf_b
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register-file port between a reader and two
// write-back sources. Define RF_BYPASS_EN to allow a combined write+read grant.
module regfile_arbiter (
    input logic              clk,
    input logic              rst_n,
    regfile_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        PTR_RD  = 2'd0,
        PTR_WR0 = 2'd1,
        PTR_WR1 = 2'd2
    } ptr_t;

    ptr_t        last_q;
    logic [1:0]  starve_q;
    logic        gnt_rd;
    logic        gnt_wr0;
    logic        gnt_wr1;
    logic        wr_gnt;
    logic        rd_take;
    logic [3:0]  wr_dst;
    logic [63:0] wr_data;
    logic        rvalid_q;
    logic [63:0] data_a_q;
    logic [63:0] data_b_q;

    // A starved read overrides the rotation; otherwise search starts after last winner.
    always_comb begin
        gnt_rd  = 1'b0;
        gnt_wr0 = 1'b0;
        gnt_wr1 = 1'b0;
        if (rst_n) begin
            if (bus.rd_valid && (starve_q == 2'd3)) begin
                gnt_rd = 1'b1;
            end else begin
                case (last_q)
                    PTR_WR0: begin
                        if (bus.wr1_valid)      gnt_wr1 = 1'b1;
                        else if (bus.rd_valid)  gnt_rd  = 1'b1;
                        else if (bus.wr0_valid) gnt_wr0 = 1'b1;
                    end
                    PTR_WR1: begin
                        if (bus.rd_valid)       gnt_rd  = 1'b1;
                        else if (bus.wr0_valid) gnt_wr0 = 1'b1;
                        else if (bus.wr1_valid) gnt_wr1 = 1'b1;
                    end
                    default: begin
                        if (bus.wr0_valid)      gnt_wr0 = 1'b1;
                        else if (bus.wr1_valid) gnt_wr1 = 1'b1;
                        else if (bus.rd_valid)  gnt_rd  = 1'b1;
                    end
                endcase
            end
        end
    end

    assign wr_gnt  = gnt_wr0 | gnt_wr1;
    assign wr_dst  = gnt_wr1 ? bus.wr1_dst  : bus.wr0_dst;
    assign wr_data = gnt_wr1 ? bus.wr1_data : bus.wr0_data;

`ifdef RF_BYPASS_EN
    logic bypass;
    assign bypass  = wr_gnt && bus.rd_valid && (bus.rd_b == wr_dst);
    assign rd_take = gnt_rd | bypass;
`else
    assign rd_take = gnt_rd;
`endif

    assign bus.rd_ready  = rd_take;
    assign bus.wr0_ready = gnt_wr0;
    assign bus.wr1_ready = gnt_wr1;

    always_comb begin
        bus.rf_sel  = 8'h00;
        bus.rf_load = 1'b0;
        bus.rf_d    = 64'h0;
        if (wr_gnt) begin
            bus.rf_sel  = {4'h0, wr_dst};
            bus.rf_load = 1'b1;
            bus.rf_d    = wr_data;
`ifdef RF_BYPASS_EN
            if (bypass) bus.rf_sel[7:4] = bus.rd_a;
`endif
        end else if (gnt_rd) begin
            bus.rf_sel = {bus.rd_a, bus.rd_b};
        end
    end

    // Port b and the write target share rf_sel[3:0], so a forwarded read takes the write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= PTR_RD;
            starve_q <= 2'd0;
            rvalid_q <= 1'b0;
            data_a_q <= 64'h0;
            data_b_q <= 64'h0;
        end else begin
            if (gnt_wr0)      last_q <= PTR_WR0;
            else if (gnt_wr1) last_q <= PTR_WR1;
            else if (gnt_rd)  last_q <= PTR_RD;

            if (!bus.rd_valid || rd_take) starve_q <= 2'd0;
            else                          starve_q <= starve_q + 2'd1;

            rvalid_q <= rd_take;
            if (rd_take) begin
`ifdef RF_BYPASS_EN
                if (bypass) begin
                    data_b_q <= wr_data;
                    data_a_q <= (bus.rd_a == wr_dst) ? wr_data : bus.rf_a;
                end else begin
                    data_a_q <= bus.rf_a;
                    data_b_q <= bus.rf_b;
                end
`else
                data_a_q <= bus.rf_a;
                data_b_q <= bus.rf_b;
`endif
            end
        end
    end

    assign bus.rd_rvalid = rvalid_q;
    assign bus.rd_data_a = data_a_q;
    assign bus.rd_data_b = data_b_q;

endmodule
